// File: rtl/vram_arb_pkg.sv
// Shared types and constants for the VRAM arbiter: FSM states, grant owners
// and the command-accept timeout.
package vram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_ISSUE       = 2'd1,
      ST_WAIT_ACCEPT = 2'd2,
      ST_WAIT_DONE   = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_A    = 2'd1,
      OWN_B    = 2'd2,
      OWN_REF  = 2'd3
   } owner_e;

   // Cycles without mc_busy before an issued command is presumed complete.
   localparam int unsigned ACCEPT_TIMEOUT = 3;
   localparam int unsigned DEBT_W         = 3;

endpackage

// File: rtl/vram_refresh_tracker.sv
// Free-running refresh interval timer plus a saturating count of refreshes
// owed to the SDRAM; flags when the debt has reached its ceiling.
module vram_refresh_tracker
#(
   parameter int unsigned REFRESH_INTERVAL = 840,
   parameter int unsigned DEBT_MAX         = 7
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enabled_i,
   input  logic       dec_i,
   output logic [2:0] debt_o,
   output logic       urgent_o,
   output logic       pending_o
);
   import vram_arb_pkg::*;

   localparam int unsigned TMR_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(REFRESH_INTERVAL - 1);
   localparam logic [DEBT_W-1:0] DEBT_TOP = DEBT_W'(DEBT_MAX);

   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [DEBT_W-1:0] debt_q, debt_d;
   logic              wrap_s;

   // Timer wrap and debt update; a simultaneous increment and refresh cancel.
   always_comb begin
      wrap_s = (tmr_q == TMR_LAST);
      tmr_d  = wrap_s ? {TMR_W{1'b0}} : tmr_q + TMR_W'(1);
      debt_d = debt_q;
      if (!enabled_i) begin
         debt_d = {DEBT_W{1'b0}};
      end else if (wrap_s && !dec_i) begin
         debt_d = (debt_q == DEBT_TOP) ? debt_q : debt_q + 3'd1;
      end else if (dec_i && !wrap_s) begin
         debt_d = (debt_q == 3'd0) ? debt_q : debt_q - 3'd1;
      end else begin
         debt_d = debt_q;
      end
   end

   // Timer and debt registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmr_q  <= {TMR_W{1'b0}};
         debt_q <= {DEBT_W{1'b0}};
      end else begin
         tmr_q  <= tmr_d;
         debt_q <= debt_d;
      end
   end

   assign debt_o    = debt_q;
   assign urgent_o  = (debt_q == DEBT_TOP);
   assign pending_o = (debt_q != 3'd0);

endmodule

// File: rtl/vram_arbiter.sv
// Single-outstanding-command scheduler sharing the SDRAM controller between
// the VDP slot (A), a secondary VRAM master (B) and periodic auto-refresh.
module vram_arbiter
#(
   parameter int unsigned ADDR_W           = 23,
   parameter int unsigned REFRESH_INTERVAL = 840,
   parameter int unsigned DEBT_MAX         = 7,
   parameter int unsigned STARVE_LIMIT     = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_req,
   input  logic              a_wr,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [15:0]       a_din,
   input  logic [1:0]        a_wdm,
   output logic              a_ack,
   output logic [15:0]       a_dout,
   output logic              a_valid,
   input  logic              b_req,
   input  logic              b_wr,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [15:0]       b_din,
   input  logic [1:0]        b_wdm,
   output logic              b_ack,
   output logic [15:0]       b_dout,
   output logic              b_valid,
   output logic              mc_read,
   output logic              mc_write,
   output logic              mc_refresh,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [15:0]       mc_din,
   output logic [1:0]        mc_wdm,
   input  logic [15:0]       mc_dout,
   input  logic              mc_busy,
   input  logic              mc_enabled,
   output logic [2:0]        refresh_debt
);
   import vram_arb_pkg::*;

   localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_LIMIT);
   localparam logic [1:0] WAIT_LAST = 2'(ACCEPT_TIMEOUT - 1);

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d, grant_s;
   logic                wr_q, wr_d;
   logic [1:0]          wait_cnt_q, wait_cnt_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                rd_q, rd_d, wrc_q, wrc_d, ref_q, ref_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         din_q, din_d;
   logic [1:0]          wdm_q, wdm_d;
   logic                a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic                a_val_q, a_val_d, b_val_q, b_val_d;
   logic [15:0]         a_dout_q, a_dout_d, b_dout_q, b_dout_d;
   logic                done_s, ref_dec_s, urgent_s, pending_s;

   vram_refresh_tracker #(
      .REFRESH_INTERVAL (REFRESH_INTERVAL),
      .DEBT_MAX         (DEBT_MAX)
   ) u_refresh (
      .clk       (clk),
      .reset_n   (reset_n),
      .enabled_i (mc_enabled),
      .dec_i     (ref_dec_s),
      .debt_o    (refresh_debt),
      .urgent_o  (urgent_s),
      .pending_o (pending_s)
   );

   // Debt is paid in the cycle the refresh command pulse is launched.
   assign ref_dec_s = (state_q == ST_ISSUE) && (owner_q == OWN_REF);

   // Grant selection, command sequencing and completion handling.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      wr_d       = wr_q;
      wait_cnt_d = wait_cnt_q;
      addr_d     = addr_q;
      din_d      = din_q;
      wdm_d      = wdm_q;
      a_dout_d   = a_dout_q;
      b_dout_d   = b_dout_q;
      rd_d       = 1'b0;
      wrc_d      = 1'b0;
      ref_d      = 1'b0;
      a_ack_d    = 1'b0;
      b_ack_d    = 1'b0;
      a_val_d    = 1'b0;
      b_val_d    = 1'b0;
      grant_s    = OWN_NONE;
      done_s     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (mc_enabled && !mc_busy) begin
               if (urgent_s)                          grant_s = OWN_REF;
               else if (b_req && starve_q == STARVE_TOP) grant_s = OWN_B;
               else if (a_req)                        grant_s = OWN_A;
               else if (pending_s)                    grant_s = OWN_REF;
               else if (b_req)                        grant_s = OWN_B;
               else                                   grant_s = OWN_NONE;
            end else begin
               grant_s = OWN_NONE;
            end
            case (grant_s)
               OWN_A: begin
                  addr_d  = a_addr;
                  din_d   = a_din;
                  wdm_d   = a_wdm;
                  wr_d    = a_wr;
                  a_ack_d = 1'b1;
               end
               OWN_B: begin
                  addr_d  = b_addr;
                  din_d   = b_din;
                  wdm_d   = b_wdm;
                  wr_d    = b_wr;
                  b_ack_d = 1'b1;
               end
               OWN_REF: wr_d = 1'b0;
               default: wr_d = wr_q;
            endcase
            if (grant_s != OWN_NONE) begin
               state_d = ST_ISSUE;
               owner_d = grant_s;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            case (owner_q)
               OWN_REF:      ref_d = 1'b1;
               OWN_A, OWN_B: begin
                  if (wr_q) wrc_d = 1'b1;
                  else      rd_d  = 1'b1;
               end
               default:      ref_d = 1'b0;
            endcase
            wait_cnt_d = 2'd0;
            state_d    = ST_WAIT_ACCEPT;
         end
         ST_WAIT_ACCEPT: begin
            if (mc_busy)                      state_d = ST_WAIT_DONE;
            else if (wait_cnt_q == WAIT_LAST) done_s = 1'b1;
            else                              wait_cnt_d = wait_cnt_q + 2'd1;
         end
         ST_WAIT_DONE: begin
            if (!mc_busy) done_s  = 1'b1;
            else          state_d = ST_WAIT_DONE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (done_s) begin
         state_d = ST_IDLE;
         owner_d = OWN_NONE;
         if (!wr_q && owner_q == OWN_A) begin
            a_dout_d = mc_dout;
            a_val_d  = 1'b1;
         end else if (!wr_q && owner_q == OWN_B) begin
            b_dout_d = mc_dout;
            b_val_d  = 1'b1;
         end else begin
            a_val_d  = 1'b0;
         end
      end else begin
         done_s = 1'b0;
      end
   end

   // Starvation guard: consecutive A grants while B is kept waiting.
   always_comb begin
      if (!b_req || grant_s == OWN_B)                     starve_d = {STARVE_W{1'b0}};
      else if (grant_s == OWN_A && starve_q != STARVE_TOP) starve_d = starve_q + STARVE_W'(1);
      else                                                starve_d = starve_q;
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_NONE;
         wr_q       <= 1'b0;
         wait_cnt_q <= 2'd0;
         starve_q   <= {STARVE_W{1'b0}};
         rd_q       <= 1'b0;
         wrc_q      <= 1'b0;
         ref_q      <= 1'b0;
         addr_q     <= {ADDR_W{1'b0}};
         din_q      <= 16'd0;
         wdm_q      <= 2'd0;
         a_ack_q    <= 1'b0;
         b_ack_q    <= 1'b0;
         a_val_q    <= 1'b0;
         b_val_q    <= 1'b0;
         a_dout_q   <= 16'd0;
         b_dout_q   <= 16'd0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         wr_q       <= wr_d;
         wait_cnt_q <= wait_cnt_d;
         starve_q   <= starve_d;
         rd_q       <= rd_d;
         wrc_q      <= wrc_d;
         ref_q      <= ref_d;
         addr_q     <= addr_d;
         din_q      <= din_d;
         wdm_q      <= wdm_d;
         a_ack_q    <= a_ack_d;
         b_ack_q    <= b_ack_d;
         a_val_q    <= a_val_d;
         b_val_q    <= b_val_d;
         a_dout_q   <= a_dout_d;
         b_dout_q   <= b_dout_d;
      end
   end

   assign a_ack      = a_ack_q;
   assign b_ack      = b_ack_q;
   assign a_valid    = a_val_q;
   assign b_valid    = b_val_q;
   assign a_dout     = a_dout_q;
   assign b_dout     = b_dout_q;
   assign mc_read    = rd_q;
   assign mc_write   = wrc_q;
   assign mc_refresh = ref_q;
   assign mc_addr    = addr_q;
   assign mc_din     = din_q;
   assign mc_wdm     = wdm_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected events, a
// negedge monitor pops and compares every DUT output event.
`timescale 1ns/1ps
module tb_vram_arbiter;

   localparam int RI = 840;

   localparam logic [3:0] K_AACK = 4'd1, K_BACK = 4'd2, K_RD = 4'd3, K_WR = 4'd4,
                          K_REF  = 4'd5, K_AVAL = 4'd6, K_BVAL = 4'd7;

   typedef struct packed {
      logic [3:0]  kind;
      logic [22:0] addr;
      logic [15:0] data;
      logic [1:0]  wdm;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        a_req, a_wr, b_req, b_wr;
   logic [22:0] a_addr, b_addr, mc_addr;
   logic [15:0] a_din, b_din, a_dout, b_dout, mc_din, mc_dout;
   logic [1:0]  a_wdm, b_wdm, mc_wdm;
   logic        a_ack, a_valid, b_ack, b_valid;
   logic        mc_read, mc_write, mc_refresh, mc_busy, mc_enabled;
   logic [2:0]  refresh_debt;

   ev_t exp_q[$];
   int  errors = 0, checks = 0;
   int  cyc = 0, cyc_aack = 0, cyc_rd = 0, cyc_aval = 0, n_aack = 0;
   int  mdl_len = 4;
   logic mdl_noacc = 1'b0, hold_busy = 1'b0;

   always #5 clk = ~clk;

   vram_arbiter dut (
      .clk(clk), .reset_n(reset_n),
      .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_din(a_din), .a_wdm(a_wdm),
      .a_ack(a_ack), .a_dout(a_dout), .a_valid(a_valid),
      .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_din(b_din), .b_wdm(b_wdm),
      .b_ack(b_ack), .b_dout(b_dout), .b_valid(b_valid),
      .mc_read(mc_read), .mc_write(mc_write), .mc_refresh(mc_refresh),
      .mc_addr(mc_addr), .mc_din(mc_din), .mc_wdm(mc_wdm),
      .mc_dout(mc_dout), .mc_busy(mc_busy), .mc_enabled(mc_enabled),
      .refresh_debt(refresh_debt)
   );

   // Memory contents are a fixed function of address; 0x00123 holds 0xBEEF.
   function automatic logic [15:0] mem_f(input logic [22:0] a);
      logic [15:0] lo;
      lo = a[15:0];
      return lo ^ 16'hBFCC;
   endfunction

   function automatic ev_t mk(input logic [3:0] k, input logic [22:0] ad,
                              input logic [15:0] d, input logic [1:0] m);
      ev_t e;
      e.kind = k; e.addr = ad; e.data = d; e.wdm = m;
      return e;
   endfunction

   task automatic push_rd_a(input logic [22:0] ad);
      exp_q.push_back(mk(K_AACK, 23'd0, 16'd0, 2'd0));
      exp_q.push_back(mk(K_RD, ad, 16'd0, 2'd0));
      exp_q.push_back(mk(K_AVAL, 23'd0, mem_f(ad), 2'd0));
   endtask

   task automatic push_rd_b(input logic [22:0] ad);
      exp_q.push_back(mk(K_BACK, 23'd0, 16'd0, 2'd0));
      exp_q.push_back(mk(K_RD, ad, 16'd0, 2'd0));
      exp_q.push_back(mk(K_BVAL, 23'd0, mem_f(ad), 2'd0));
   endtask

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   task automatic sb_check(input ev_t got);
      ev_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL sb_unexpected: got kind=%0d addr=%h data=%h wdm=%b, required no event",
                  got.kind, got.addr, got.data, got.wdm);
      end else begin
         e = exp_q.pop_front();
         if (got !== e) begin
            errors++;
            $display("FAIL sb_event: got kind=%0d addr=%h data=%h wdm=%b, required kind=%0d addr=%h data=%h wdm=%b",
                     got.kind, got.addr, got.data, got.wdm, e.kind, e.addr, e.data, e.wdm);
         end
      end
   endtask

   // Monitor: every output event is matched against the expected queue.
   initial begin : monitor
      forever begin
         @(negedge clk);
         cyc++;
         if (reset_n) begin
            if (a_ack)      begin cyc_aack = cyc; n_aack++; sb_check(mk(K_AACK, 23'd0, 16'd0, 2'd0)); end
            if (b_ack)      sb_check(mk(K_BACK, 23'd0, 16'd0, 2'd0));
            if (mc_read)    begin cyc_rd = cyc; sb_check(mk(K_RD, mc_addr, 16'd0, 2'd0)); end
            if (mc_write)   sb_check(mk(K_WR, mc_addr, mc_din, mc_wdm));
            if (mc_refresh) sb_check(mk(K_REF, 23'd0, 16'd0, 2'd0));
            if (a_valid)    begin cyc_aval = cyc; sb_check(mk(K_AVAL, 23'd0, a_dout, 2'd0)); end
            if (b_valid)    sb_check(mk(K_BVAL, 23'd0, b_dout, 2'd0));
         end
      end
   end

   // Memory-controller model: busy for mdl_len cycles after each command.
   initial begin : mc_model
      int cnt;
      cnt = 0;
      mc_busy = 1'b0;
      mc_dout = 16'd0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            cnt = 0;
         end else if (mc_read || mc_write || mc_refresh) begin
            if (mc_read) mc_dout = mem_f(mc_addr);
            if (!mdl_noacc) cnt = mdl_len;
         end else if (cnt > 0) begin
            cnt--;
         end
         mc_busy = hold_busy || (cnt > 0);
      end
   end

   task automatic wait_ack_a(input string nm);
      int n = 0;
      do begin @(negedge clk); n++; end while (!a_ack && n < 400);
      if (!a_ack) begin
         checks++; errors++;
         $display("FAIL %s: a_ack not seen after %0d cycles, required within 400", nm, n);
      end
   endtask

   task automatic wait_ack_b(input string nm);
      int n = 0;
      do begin @(negedge clk); n++; end while (!b_ack && n < 400);
      if (!b_ack) begin
         checks++; errors++;
         $display("FAIL %s: b_ack not seen after %0d cycles, required within 400", nm, n);
      end
   endtask

   task automatic start_a(input logic wr, input logic [22:0] ad, input logic [15:0] d, input logic [1:0] m);
      a_wr = wr; a_addr = ad; a_din = d; a_wdm = m; a_req = 1'b1;
   endtask

   task automatic do_a(input logic wr, input logic [22:0] ad, input logic [15:0] d, input logic [1:0] m);
      start_a(wr, ad, d, m);
      wait_ack_a("a_ack");
      a_req = 1'b0;
   endtask

   task automatic do_b(input logic wr, input logic [22:0] ad, input logic [15:0] d, input logic [1:0] m);
      b_wr = wr; b_addr = ad; b_din = d; b_wdm = m; b_req = 1'b1;
      wait_ack_b("b_ack");
      b_req = 1'b0;
   endtask

   task automatic drv_a_stream(input int cnt, input logic [22:0] base);
      a_wr = 1'b0; a_din = 16'd0; a_wdm = 2'd0;
      for (int i = 0; i < cnt; i++) begin
         a_addr = base + 23'(i); a_req = 1'b1;
         wait_ack_a("starve_a_ack");
      end
      a_req = 1'b0;
   endtask

   task automatic drv_b_stream(input int cnt, input logic [22:0] base);
      b_wr = 1'b0; b_din = 16'd0; b_wdm = 2'd0;
      for (int i = 0; i < cnt; i++) begin
         b_addr = base + 23'(i); b_req = 1'b1;
         wait_ack_b("starve_b_ack");
      end
      b_req = 1'b0;
   endtask

   task automatic drain(input string nm, input int bound);
      int n = 0;
      while (exp_q.size() != 0 && n < bound) begin @(negedge clk); n++; end
      if (exp_q.size() != 0) begin
         checks++; errors++;
         $display("FAIL %s: %0d expected events pending after %0d cycles, required 0", nm, exp_q.size(), n);
         exp_q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_outs_zero(input string nm);
      check(nm, {a_ack, a_valid, a_dout, b_ack, b_valid, b_dout, mc_read, mc_write, mc_refresh,
                 mc_addr, mc_din, mc_wdm, refresh_debt}, 128'd0);
   endtask

   initial begin : stim
      int n, ia, ib, n0;
      reset_n = 1'b1; mc_enabled = 1'b1;
      a_req = 1'b0; a_wr = 1'b0; a_addr = 23'd0; a_din = 16'd0; a_wdm = 2'd0;
      b_req = 1'b0; b_wr = 1'b0; b_addr = 23'd0; b_din = 16'd0; b_wdm = 2'd0;
      #2 reset_n = 1'b0;
      #1 check_outs_zero("reset_outputs");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("reset_debt", refresh_debt, 3'd0);

      // Single A read with a 4-cycle busy window.
      mdl_len = 4;
      push_rd_a(23'h00123);
      do_a(1'b0, 23'h00123, 16'd0, 2'd0);
      drain("a_read", 100);
      check("a_read_cmd_latency", cyc_rd - cyc_aack, 1);
      check("a_read_valid_latency", cyc_aval - cyc_rd, 5);
      check("a_dout_beef", a_dout, 16'hBEEF);

      // B masked write: command fields match, no b_valid.
      exp_q.push_back(mk(K_BACK, 23'd0, 16'd0, 2'd0));
      exp_q.push_back(mk(K_WR, 23'h45678, 16'h5A5A, 2'b01));
      do_b(1'b1, 23'h45678, 16'h5A5A, 2'b01);
      drain("b_write", 100);

      // Controller never accepts: completes after the accept timeout.
      mdl_noacc = 1'b1;
      push_rd_a(23'h00321);
      do_a(1'b0, 23'h00321, 16'd0, 2'd0);
      drain("a_timeout", 100);
      check("a_timeout_latency", cyc_aval - cyc_rd, 3);
      mdl_noacc = 1'b0;

      // B read; A's read data must be held.
      push_rd_b(23'h00777);
      do_b(1'b0, 23'h00777, 16'd0, 2'd0);
      drain("b_read", 100);
      check("a_dout_hold", a_dout, mem_f(23'h00321));
      check("b_dout_val", b_dout, mem_f(23'h00777));

      // Continuous A and B requests: AAAAAAAAB repeating.
      mdl_len = 2;
      ia = 0; ib = 0;
      for (int i = 0; i < 18; i++) begin
         if (i % 9 == 8) begin push_rd_b(23'h10000 + 23'(ib)); ib++; end
         else            begin push_rd_a(23'h20000 + 23'(ia)); ia++; end
      end
      fork
         drv_a_stream(16, 23'h20000);
         drv_b_stream(2, 23'h10000);
      join
      drain("starve", 400);

      // Reset while waiting for completion: everything aborts, no a_valid.
      mdl_len = 20;
      exp_q.push_back(mk(K_AACK, 23'd0, 16'd0, 2'd0));
      exp_q.push_back(mk(K_RD, 23'h00555, 16'd0, 2'd0));
      do_a(1'b0, 23'h00555, 16'd0, 2'd0);
      n = 0;
      while (exp_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
      repeat (3) @(negedge clk);
      reset_n = 1'b0;
      #1 check_outs_zero("abort_reset_outputs");
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      drain("abort_reset", 50);
      repeat (30) @(negedge clk);

      // Controller held busy: debt accumulates and saturates.
      mdl_len = 3;
      hold_busy = 1'b1;
      n = 0;
      while (refresh_debt != 3'd7 && n < 8 * RI + 100) begin @(negedge clk); n++; end
      check("debt_reaches_max", refresh_debt, 3'd7);
      check("debt_fill_time", (n > 6 * RI) && (n <= 7 * RI), 1'b1);
      repeat (RI + 10) @(negedge clk);
      check("debt_saturates", refresh_debt, 3'd7);

      // Urgent refresh beats a simultaneous A request, then debt drains.
      exp_q.push_back(mk(K_REF, 23'd0, 16'd0, 2'd0));
      push_rd_a(23'h00999);
      for (int i = 0; i < 6; i++) exp_q.push_back(mk(K_REF, 23'd0, 16'd0, 2'd0));
      start_a(1'b0, 23'h00999, 16'd0, 2'd0);
      repeat (2) @(negedge clk);
      hold_busy = 1'b0;
      wait_ack_a("urgent_a_ack");
      a_req = 1'b0;
      drain("refresh_drain", 600);
      check("debt_drained", refresh_debt, 3'd0);

      // mc_enabled drops mid-command: it completes, then no more grants.
      mdl_len = 6;
      push_rd_a(23'h00AAA);
      do_a(1'b0, 23'h00AAA, 16'd0, 2'd0);
      mc_enabled = 1'b0;
      @(negedge clk);
      n0 = n_aack;
      start_a(1'b0, 23'h00BBB, 16'd0, 2'd0);
      drain("en_drop_complete", 100);
      repeat (20) @(negedge clk);
      check("en_low_no_grant", n_aack - n0, 0);
      push_rd_a(23'h00BBB);
      mc_enabled = 1'b1;
      wait_ack_a("en_back_a_ack");
      a_req = 1'b0;
      drain("en_back", 100);

      // Debt is cleared while the controller is not enabled.
      hold_busy = 1'b1;
      n = 0;
      while (refresh_debt == 3'd0 && n < RI + 100) begin @(negedge clk); n++; end
      check("debt_increment", refresh_debt, 3'd1);
      mc_enabled = 1'b0;
      @(negedge clk);
      check("debt_clear_disabled", refresh_debt, 3'd0);
      mc_enabled = 1'b1;
      hold_busy = 1'b0;
      repeat (10) @(negedge clk);
      check("sb_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
